// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD command/pixel path.
//   - ILI9341 command bytes used by the init and tile-fill sequences
//   - RGB565 palette entries indexed by object code
//   - seq_state_t: sequencer FSM state encoding
package lcd_pkg;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   localparam logic [15:0] PAL_WHITE  = 16'hFFFF;
   localparam logic [15:0] PAL_VIOLET = 16'h901E;
   localparam logic [15:0] PAL_INDIGO = 16'h6815;
   localparam logic [15:0] PAL_RED    = 16'hF800;
   localparam logic [15:0] PAL_NAVY   = 16'h0814;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_CMD,
      ST_INIT_WAIT,
      ST_WIN,
      ST_PIX,
      ST_FIN
   } seq_state_t;

endpackage

// File: rtl/lcd_palette.sv
// lcd_palette: combinational object code -> RGB565 colour lookup.
// Shared between the tile sequencer and the preview path.
// Ports:
//   obj_code_i  in  3   palette index
//   rgb_o       out 16  RGB565 colour (unused codes map to white)
module lcd_palette
   import lcd_pkg::*;
(
   input  logic [2:0]  obj_code_i,
   output logic [15:0] rgb_o
);

   always_comb begin
      case (obj_code_i)
         3'd1:    rgb_o = PAL_VIOLET;
         3'd2:    rgb_o = PAL_INDIGO;
         3'd3:    rgb_o = PAL_RED;
         3'd4:    rgb_o = PAL_NAVY;
         default: rgb_o = PAL_WHITE;
      endcase
   end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: drives an 8-bit DBI panel (ILI9341 command set) through
// a valid/ready byte stream. Runs the power-up sequence with programmable
// delays, or fills one CELL_PX x CELL_PX grid tile with a palette colour.
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   start_init, start_tile  sequence requests, sampled only when idle
//   tile_x, tile_y          tile coordinates, latched on accepted start
//   obj_code                palette index, latched on accepted start
//   busy                    sequence in progress
//   done                    one-cycle completion pulse
//   byte_data, byte_dcx     registered byte and D/C flag (0 = command)
//   byte_valid, byte_ready  handshake; transfer on valid && ready
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned CELL_PX    = 20,
   parameter int unsigned GRID_W     = 4,
   parameter int unsigned INIT_DELAY = 50000,
   parameter int unsigned DLY_W      = 17
)(
   input  logic              clk,
   input  logic              nrst,
   input  logic              start_init,
   input  logic              start_tile,
   input  logic [GRID_W-1:0] tile_x,
   input  logic [GRID_W-1:0] tile_y,
   input  logic [2:0]        obj_code,
   output logic              busy,
   output logic              done,
   output logic [7:0]        byte_data,
   output logic              byte_dcx,
   output logic              byte_valid,
   input  logic              byte_ready
);

   localparam int unsigned PIX_N = CELL_PX * CELL_PX;
   localparam int unsigned PIX_W = $clog2(PIX_N + 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(INIT_DELAY - 1);

   seq_state_t        state_q, state_d;
   logic [3:0]        step_q, step_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              lo_q, lo_d;
   logic [GRID_W-1:0] x_q, x_d, y_q, y_d;
   logic [2:0]        obj_q, obj_d;
   logic [7:0]        data_q, data_d;
   logic              dcx_q, dcx_d;
   logic              valid_q, valid_d;

   logic              xfer;
   logic [15:0]       rgb;
   logic [15:0]       sc, ec, sp, ep;
   logic [3:0]        win_nxt;
   logic [7:0]        win_byte;
   logic              win_dcx;

   assign xfer = valid_q && byte_ready;

   assign sc = 16'(x_q) * 16'(CELL_PX);
   assign ec = sc + 16'(CELL_PX - 1);
   assign sp = 16'(y_q) * 16'(CELL_PX);
   assign ep = sp + 16'(CELL_PX - 1);

   lcd_palette u_palette (
      .obj_code_i (obj_q),
      .rgb_o      (rgb)
   );

   // Window byte that follows the one currently offered (step_q).
   always_comb begin
      win_nxt  = step_q + 4'd1;
      win_dcx  = 1'b1;
      win_byte = CMD_RAMWR;
      case (win_nxt)
         4'd1:    win_byte = sc[15:8];
         4'd2:    win_byte = sc[7:0];
         4'd3:    win_byte = ec[15:8];
         4'd4:    win_byte = ec[7:0];
         4'd5:    begin win_byte = CMD_PASET; win_dcx = 1'b0; end
         4'd6:    win_byte = sp[15:8];
         4'd7:    win_byte = sp[7:0];
         4'd8:    win_byte = ep[15:8];
         4'd9:    win_byte = ep[7:0];
         default: begin win_byte = CMD_RAMWR; win_dcx = 1'b0; end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         dly_q   <= '0;
         pix_q   <= '0;
         lo_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         obj_q   <= '0;
         data_q  <= 8'h00;
         dcx_q   <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         dly_q   <= dly_d;
         pix_q   <= pix_d;
         lo_q    <= lo_d;
         x_q     <= x_d;
         y_q     <= y_d;
         obj_q   <= obj_d;
         data_q  <= data_d;
         dcx_q   <= dcx_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic. The outgoing byte is registered: whenever the current
   // byte transfers, the following byte is loaded in the same edge, so a
   // stalled byte simply holds its registers.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      dly_d   = dly_q;
      pix_d   = pix_q;
      lo_d    = lo_q;
      x_d     = x_q;
      y_d     = y_q;
      obj_d   = obj_q;
      data_d  = data_q;
      dcx_d   = dcx_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (start_init) begin
               state_d = ST_INIT_CMD;
               step_d  = '0;
               data_d  = CMD_SWRESET;
               dcx_d   = 1'b0;
               valid_d = 1'b1;
            end else if (start_tile) begin
               state_d = ST_WIN;
               x_d     = tile_x;
               y_d     = tile_y;
               obj_d   = obj_code;
               step_d  = '0;
               data_d  = CMD_CASET;
               dcx_d   = 1'b0;
               valid_d = 1'b1;
            end
         end
         // step_q indexes the init byte on offer: 01, 28, 11, 29.
         ST_INIT_CMD: begin
            if (xfer) begin
               step_d = step_q + 4'd1;
               case (step_q)
                  4'd0, 4'd2: begin
                     state_d = ST_INIT_WAIT;
                     dly_d   = '0;
                     valid_d = 1'b0;
                  end
                  4'd1:    data_d = CMD_SLPOUT;
                  default: begin
                     state_d = ST_FIN;
                     valid_d = 1'b0;
                  end
               endcase
            end
         end
         ST_INIT_WAIT: begin
            if (dly_q == DLY_LAST) begin
               state_d = ST_INIT_CMD;
               data_d  = (step_q == 4'd1) ? CMD_DISPOFF : CMD_DISPON;
               dcx_d   = 1'b0;
               valid_d = 1'b1;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         ST_WIN: begin
            if (xfer) begin
               if (step_q == 4'd10) begin
                  state_d = ST_PIX;
                  pix_d   = '0;
                  lo_d    = 1'b0;
                  data_d  = rgb[15:8];
                  dcx_d   = 1'b1;
               end else begin
                  step_d = win_nxt;
                  data_d = win_byte;
                  dcx_d  = win_dcx;
               end
            end
         end
         ST_PIX: begin
            if (xfer) begin
               if (!lo_q) begin
                  lo_d   = 1'b1;
                  data_d = rgb[7:0];
               end else if (pix_q == PIX_LAST) begin
                  state_d = ST_FIN;
                  valid_d = 1'b0;
               end else begin
                  pix_d  = pix_q + PIX_W'(1);
                  lo_d   = 1'b0;
                  data_d = rgb[15:8];
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            step_d  = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
      done       = (state_q == ST_FIN);
      byte_data  = data_q;
      byte_dcx   = dcx_q;
      byte_valid = valid_q;
   end

endmodule
